// File: rtl/sram_ahb_ctrl.sv
// AHB-Lite slave that sequences an async 16-bit SRAM through the SRAM PHY.
// It splits bus transfers into halfword access windows and recovers read data across the PHY round trip.
module sram_ahb_ctrl #(
    parameter int N_SRAM_A = 18,
    parameter int W_ADDR   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ahbls_hready,
    output logic                ahbls_hready_resp,
    output logic                ahbls_hresp,
    input  logic [W_ADDR-1:0]   ahbls_haddr,
    input  logic                ahbls_hwrite,
    input  logic [1:0]          ahbls_htrans,
    input  logic [2:0]          ahbls_hsize,
    input  logic [31:0]         ahbls_hwdata,
    output logic [31:0]         ahbls_hrdata,
    input  logic                ahbls_hsel,
    input  logic [3:0]          cfg_rd_wait,
    input  logic [3:0]          cfg_wr_wait,
    output logic [N_SRAM_A-1:0] ctrl_addr,
    output logic [15:0]         ctrl_dq_out,
    output logic [15:0]         ctrl_dq_oe,
    input  logic [15:0]         ctrl_dq_in,
    output logic                ctrl_ce_n,
    output logic                ctrl_we_n,
    output logic                ctrl_oe_n,
    output logic [1:0]          ctrl_byte_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_READ_DRAIN, S_TURNAROUND
    } state_t;

    state_t              state_q, state_d;
    logic [N_SRAM_A-1:0] addr_q, addr_d;
    logic [3:0]          wcnt_q, wcnt_d, wait_q, wait_d;
    logic                word_q, word_d, byte_q, byte_d;
    logic                second_q, second_d, first_q, first_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         hwdata_q, hwdata_d;
    logic [15:0]         rd_lo_q, rd_lo_d;
    logic [1:0]          vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;

    logic        accept, win_end, last_win, rd_done, start;
    logic [31:0] wsrc;
    logic [7:0]  wbyte, rbyte;

    logic unused_bits;
    assign unused_bits = ^{ahbls_haddr[W_ADDR-1:N_SRAM_A+1], ahbls_hsize[2], ahbls_htrans[0]};

    assign accept   = ahbls_hsel & ahbls_htrans[1] & ahbls_hready;
    assign win_end  = (wcnt_q == 4'd0);
    assign last_win = !word_q || second_q;
    // vld_pipe_q[1] marks the cycle the PHY returns data for a read window that ended two cycles ago
    assign rd_done  = (state_q == S_READ_DRAIN) && vld_pipe_q[1] && last_pipe_q[1];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        wait_d      = wait_q;
        word_d      = word_q;
        byte_d      = byte_q;
        second_d    = second_q;
        first_d     = 1'b0;
        lane_d      = lane_q;
        hwdata_d    = hwdata_q;
        rd_lo_d     = rd_lo_q;
        vld_pipe_d  = {vld_pipe_q[0], (state_q == S_READ) && win_end};
        last_pipe_d = {last_pipe_q[0], last_win};
        start       = 1'b0;

        if (state_q == S_WRITE && first_q)
            hwdata_d = ahbls_hwdata;
        if (vld_pipe_q[1] && !last_pipe_q[1])
            rd_lo_d = ctrl_dq_in;

        case (state_q)
            S_IDLE: start = accept;
            S_WRITE, S_READ: begin
                if (!win_end) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (!last_win) begin
                    second_d = 1'b1;
                    wcnt_d   = wait_q;
                    addr_d   = addr_q + {{(N_SRAM_A-1){1'b0}}, 1'b1};
                end else if (state_q == S_READ) begin
                    state_d = S_READ_DRAIN;
                end else begin
                    start = accept;
                    if (!accept) state_d = S_IDLE;
                end
            end
            S_READ_DRAIN: begin
                if (rd_done) begin
                    start = accept;
                    if (!accept) state_d = S_IDLE;
                end
            end
            S_TURNAROUND: state_d = S_READ;
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            addr_d   = {ahbls_haddr[N_SRAM_A:2], ahbls_haddr[1] & ~ahbls_hsize[1]};
            word_d   = ahbls_hsize[1];
            byte_d   = ~ahbls_hsize[1] & ~ahbls_hsize[0];
            lane_d   = ahbls_haddr[1:0];
            second_d = 1'b0;
            first_d  = 1'b1;
            if (ahbls_hwrite) begin
                state_d = S_WRITE;
                wait_d  = cfg_wr_wait;
                wcnt_d  = cfg_wr_wait;
            end else begin
                // SRAM needs a dead cycle between driving dq and enabling its outputs
                state_d = (state_q == S_WRITE) ? S_TURNAROUND : S_READ;
                wait_d  = cfg_rd_wait;
                wcnt_d  = cfg_rd_wait;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wcnt_q      <= '0;
            wait_q      <= '0;
            word_q      <= 1'b0;
            byte_q      <= 1'b0;
            second_q    <= 1'b0;
            first_q     <= 1'b0;
            lane_q      <= '0;
            hwdata_q    <= '0;
            rd_lo_q     <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
            wait_q      <= wait_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            second_q    <= second_d;
            first_q     <= first_d;
            lane_q      <= lane_d;
            hwdata_q    <= hwdata_d;
            rd_lo_q     <= rd_lo_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    always_comb begin
        wsrc  = first_q ? ahbls_hwdata : hwdata_q;
        wbyte = wsrc[{lane_q, 3'b000} +: 8];
        rbyte = lane_q[0] ? ctrl_dq_in[15:8] : ctrl_dq_in[7:0];

        ctrl_addr   = addr_q;
        ctrl_ce_n   = !(state_q == S_WRITE || state_q == S_READ);
        ctrl_we_n   = (state_q != S_WRITE);
        ctrl_oe_n   = (state_q != S_READ);
        ctrl_dq_oe  = (state_q == S_WRITE) ? 16'hffff : 16'h0000;
        ctrl_byte_n = 2'b11;
        if (!ctrl_ce_n)
            ctrl_byte_n = byte_q ? (lane_q[0] ? 2'b01 : 2'b10) : 2'b00;

        ctrl_dq_out = 16'h0000;
        if (state_q == S_WRITE) begin
            if (word_q)
                ctrl_dq_out = second_q ? wsrc[31:16] : wsrc[15:0];
            else if (byte_q)
                ctrl_dq_out = {wbyte, wbyte};
            else
                ctrl_dq_out = lane_q[1] ? wsrc[31:16] : wsrc[15:0];
        end

        ahbls_hresp       = 1'b0;
        ahbls_hready_resp = 1'b0;
        case (state_q)
            S_IDLE:       ahbls_hready_resp = 1'b1;
            S_WRITE:      ahbls_hready_resp = win_end && last_win;
            S_READ_DRAIN: ahbls_hready_resp = rd_done;
            default:      ahbls_hready_resp = 1'b0;
        endcase

        ahbls_hrdata = 32'h0;
        if (rd_done) begin
            if (word_q)
                ahbls_hrdata = {ctrl_dq_in, rd_lo_q};
            else if (byte_q)
                ahbls_hrdata = {4{rbyte}};
            else
                ahbls_hrdata = {2{ctrl_dq_in}};
        end
    end

endmodule
